// File: rtl/bitcell_pkg.sv
// Shared definitions for the NAND-latch bitcell array and its access
// sequencer.
//   ST_*  : 2-bit state encoding, shared with the array FSM
//   OP_*  : requester op encoding (1 = write, 0 = read)
package bitcell_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b11;
  localparam logic [1:0] ST_SETUP  = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
//   req[1:0] : request lines
//   ptr      : tie-break preference, 0 = requester 0, 1 = requester 1
//   en       : grants are only issued while en is high
//   gnt[1:0] : one-hot grant, or zero
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contention: the pointer decides.
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/bitcell_array_arbiter.sv
// Round-robin arbiter and access sequencer for the bitcell array.
// Two requesters share one array; each transaction walks
// IDLE -> SETUP -> ACCESS -> DONE and takes four cycles.
//   clk, rst                        : clock, synchronous active-high reset
//   req*/op*/addr*/wdata*           : requester side inputs
//   ack0, ack1                      : one-cycle completion pulses
//   rdata, err                      : registered result, held until next DONE
//   mem_sel/mem_rw/mem_we/mem_wdata : array control (one-hot row select)
//   mem_rdata                       : selected-row data from the array
//   state_ab                        : current FSM state for debug
//
// Handshake: reqN is a level that the requester keeps high until ackN
// pulses. Requests and op/addr/wdata are sampled only in IDLE; the values
// are latched on grant, so later changes or a dropped request do not affect
// the transaction in flight. A request still high after its ack counts as a
// new request.
module bitcell_array_arbiter
  import bitcell_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             ack0,
  input  logic             req1,
  input  logic             op1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic [DEPTH-1:0] mem_sel,
  output logic             mem_rw,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [1:0]       state_ab
);

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;       // 1 = requester 1 wins the next tie
  logic             gnt1_q, gnt1_d;   // 1 = requester 1 owns the transaction
  logic             op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [1:0]       gnt;
  logic             oor;
  logic [DEPTH-1:0] sel_row;

  rr_arbiter2 u_rr (
    .req (({req1, req0})),
    .ptr (rr_q),
    .en  (state_q == ST_IDLE),
    .gnt (gnt)
  );

  // Addresses past the last row (non power-of-two DEPTH) never touch the array.
  assign oor     = (int'(addr_q) >= DEPTH);
  assign sel_row = oor ? '0 : ({{(DEPTH-1){1'b0}}, 1'b1} << addr_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      gnt1_q  <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt1_q  <= gnt1_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt1_d  = gnt1_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          gnt1_d  = gnt[1];
          op_d    = gnt[1] ? op1    : op0;
          addr_d  = gnt[1] ? addr1  : addr0;
          wdata_d = gnt[1] ? wdata1 : wdata0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // Result registers update as DONE is entered and hold afterwards.
        err_d   = oor;
        rdata_d = (op_q == OP_READ && !oor) ? mem_rdata : '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rr_d    = ~gnt1_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; everything array-facing is quiet outside SETUP/ACCESS.
  always_comb begin
    mem_sel   = '0;
    mem_rw    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state_q)
      ST_SETUP: begin
        mem_sel   = sel_row;
        mem_rw    = op_q;
        mem_wdata = wdata_q;
      end
      ST_ACCESS: begin
        mem_sel   = sel_row;
        mem_rw    = op_q;
        mem_wdata = wdata_q;
        mem_we    = (op_q == OP_WRITE) && !oor;
      end
      ST_DONE: begin
        ack0 = ~gnt1_q;
        ack1 = gnt1_q;
      end
      default: ;
    endcase
  end

  assign rdata    = rdata_q;
  assign err      = err_q;
  assign state_ab = state_q;

endmodule

// File: tb/tb_bitcell_array_arbiter.sv
module tb_bitcell_array_arbiter;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance, DEPTH = 4
  logic          req0, op0, req1, op1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          ack0, ack1, err, mem_rw, mem_we;
  logic [W-1:0]  rdata, mem_wdata, mem_rdata;
  logic [D-1:0]  mem_sel;
  logic [1:0]    state_ab;

  // second instance, DEPTH = 3, for out-of-range addresses
  logic          req0_3, op0_3;
  logic [1:0]    addr0_3;
  logic [W-1:0]  wdata0_3;
  logic          ack0_3, ack1_3, err_3, mem_rw_3, mem_we_3;
  logic [W-1:0]  rdata_3, mem_wdata_3;
  logic [2:0]    mem_sel_3;
  logic [1:0]    state_ab_3;

  bitcell_array_arbiter #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err), .mem_sel(mem_sel), .mem_rw(mem_rw),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_ab(state_ab)
  );

  bitcell_array_arbiter #(.WIDTH(W), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(req0_3), .op0(op0_3), .addr0(addr0_3), .wdata0(wdata0_3), .ack0(ack0_3),
    .req1(1'b0), .op1(1'b0), .addr1(2'b00), .wdata1(4'h0), .ack1(ack1_3),
    .rdata(rdata_3), .err(err_3), .mem_sel(mem_sel_3), .mem_rw(mem_rw_3),
    .mem_we(mem_we_3), .mem_wdata(mem_wdata_3), .mem_rdata(4'hF),
    .state_ab(state_ab_3)
  );

  // ---------------- behavioural bitcell array ----------------
  logic [W-1:0] arr [D];
  logic         arr_clr;

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int i = 0; i < D; i++) arr[i] <= '0;
    end else if (mem_we) begin
      for (int i = 0; i < D; i++) if (mem_sel[i]) arr[i] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < D; i++) if (mem_sel[i]) mem_rdata = mem_rdata | arr[i];
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic run_inv = 1'b0;
  logic [W:0] exp_q[$];   // {winner, expected rdata}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Array-safety properties, checked every cycle once running.
  always @(negedge clk) begin
    if (run_inv) begin
      chk("we_outside_access", 32'(mem_we && (state_ab != 2'b01)), 32'd0);
      chk("sel_onehot0", 32'($onehot0(mem_sel)), 32'd1);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic new_req(input int who);
    if (who == 0) begin
      op0    = 1'($urandom_range(0, 1));
      addr0  = AW'($urandom_range(0, D - 1));
      wdata0 = W'($urandom());
    end else begin
      op1    = 1'($urandom_range(0, 1));
      addr1  = AW'($urandom_range(0, D - 1));
      wdata1 = W'($urandom());
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         r0, o0;
    logic [AW-1:0] a0;
    logic [W-1:0] d0;
    logic         r1, o1;
    logic [AW-1:0] a1;
    logic [W-1:0] d1;
    logic [D-1:0] e_sel;
    logic         e_we;
    logic         e_ack0, e_ack1;
    logic [W-1:0] e_rd;
  } vec_t;

  vec_t vt [8];

  logic [W-1:0] mem_m [D];
  logic         p0, p1, rr_m, win, wop, got;
  logic [AW-1:0] wa;
  logic [W-1:0] wd, e_wd;
  logic [W:0]   exp_e;
  logic [1:0]   st_seq [4];
  int           cyc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 1'b1, 2'd2, 4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'h0};
    vt[1] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'hA};
    vt[2] = '{1'b1, 1'b1, 2'd1, 4'h5, 1'b1, 1'b1, 2'd3, 4'hC, 4'b0010, 1'b1, 1'b1, 1'b0, 4'h0};
    vt[3] = '{1'b1, 1'b0, 2'd1, 4'h0, 1'b1, 1'b1, 2'd3, 4'hC, 4'b1000, 1'b1, 1'b0, 1'b1, 4'h0};
    vt[4] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'hC};
    vt[5] = '{1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'h5};
    vt[6] = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'hA};
    vt[7] = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'h0};
    st_seq[0] = 2'b11; st_seq[1] = 2'b00; st_seq[2] = 2'b01; st_seq[3] = 2'b10;

    rst = 1'b1; arr_clr = 1'b1;
    req0 = 0; op0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; op1 = 0; addr1 = '0; wdata1 = '0;
    req0_3 = 0; op0_3 = 0; addr0_3 = '0; wdata0_3 = '0;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_state", 32'(state_ab), 32'h3);
    chk("rst_ack", 32'({ack0, ack1}), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_sel", 32'(mem_sel), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0; arr_clr = 1'b0; run_inv = 1'b1;

    // ---- table-driven transactions ----
    for (int i = 0; i < 8; i++) begin
      req0 = vt[i].r0; op0 = vt[i].o0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
      req1 = vt[i].r1; op1 = vt[i].o1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
      e_wd = vt[i].e_ack1 ? vt[i].d1 : vt[i].d0;
      tick();
      chk("tbl_setup_state", 32'(state_ab), 32'h0);
      chk("tbl_setup_sel", 32'(mem_sel), 32'(vt[i].e_sel));
      chk("tbl_setup_we", 32'(mem_we), 32'h0);
      chk("tbl_setup_rw", 32'(mem_rw), 32'(vt[i].e_we));
      // Drop requests and disturb inputs: the latched transaction must finish.
      req0 = 0; req1 = 0; op0 = ~op0; op1 = ~op1;
      addr0 = ~addr0; addr1 = ~addr1; wdata0 = ~wdata0; wdata1 = ~wdata1;
      tick();
      chk("tbl_access_state", 32'(state_ab), 32'h1);
      chk("tbl_access_sel", 32'(mem_sel), 32'(vt[i].e_sel));
      chk("tbl_access_we", 32'(mem_we), 32'(vt[i].e_we));
      chk("tbl_access_wdata", 32'(mem_wdata), 32'(e_wd));
      tick();
      chk("tbl_done_state", 32'(state_ab), 32'h2);
      chk("tbl_done_ack0", 32'(ack0), 32'(vt[i].e_ack0));
      chk("tbl_done_ack1", 32'(ack1), 32'(vt[i].e_ack1));
      chk("tbl_done_rdata", 32'(rdata), 32'(vt[i].e_rd));
      chk("tbl_done_err", 32'(err), 32'h0);
      chk("tbl_done_sel", 32'(mem_sel), 32'h0);
      tick();
      chk("tbl_idle_state", 32'(state_ab), 32'h3);
      chk("tbl_idle_ack", 32'({ack0, ack1}), 32'h0);
      chk("tbl_idle_rdata_hold", 32'(rdata), 32'(vt[i].e_rd));
    end

    // ---- randomized traffic against a transaction-level model ----
    rst = 1'b1; arr_clr = 1'b1; req0 = 0; req1 = 0;
    tick();
    rst = 1'b0; arr_clr = 1'b0;
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    p0 = 0; p1 = 0; rr_m = 0;
    for (int t = 0; t < 80; t++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; new_req(0); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; new_req(1); end
      if (!p0 && !p1) begin p0 = 1; new_req(0); end
      req0 = p0; req1 = p1;
      win = (p0 && p1) ? rr_m : p1;
      wop = win ? op1 : op0;
      wa  = win ? addr1 : addr0;
      wd  = win ? wdata1 : wdata0;
      if (wop) begin
        mem_m[wa] = wd;
        exp_q.push_back({win, {W{1'b0}}});
      end else begin
        exp_q.push_back({win, mem_m[wa]});
      end
      cyc = 0; got = 0;
      while (!got && cyc < 8) begin
        tick();
        cyc++;
        if (ack0 || ack1) got = 1;
      end
      chk("rand_ack_seen", 32'(got), 32'h1);
      exp_e = exp_q.pop_front();
      if (got) begin
        chk("rand_latency", 32'(cyc), 32'd3);
        chk("rand_who", 32'({ack1, ack0}), exp_e[W] ? 32'h2 : 32'h1);
        chk("rand_rdata", 32'(rdata), 32'(exp_e[W-1:0]));
        chk("rand_err", 32'(err), 32'h0);
      end
      if (win) begin p1 = 0; req1 = 0; end else begin p0 = 0; req0 = 0; end
      rr_m = ~win;
      tick();
    end
    req0 = 0; req1 = 0;

    // ---- continuous requests from reset: alternating grants ----
    rst = 1'b1; req0 = 1; req1 = 1; op0 = 0; op1 = 0; addr0 = 2'd1; addr1 = 2'd2;
    tick();
    rst = 1'b0;
    chk("cont_state", 32'(state_ab), 32'(st_seq[0]));
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("cont_state", 32'(state_ab), 32'(st_seq[k % 4]));
      if (k % 4 == 3) begin
        chk("cont_ack0", 32'(ack0), 32'(((k / 4) % 2) == 0));
        chk("cont_ack1", 32'(ack1), 32'(((k / 4) % 2) == 1));
      end else begin
        chk("cont_no_ack", 32'({ack0, ack1}), 32'h0);
      end
    end

    // ---- reset during ACCESS of a write ----
    req0 = 0; req1 = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1; op0 = 1; addr0 = 2'd0; wdata0 = 4'h3;   // complete one, pointer moves to 1
    tick(); req0 = 0; tick(); tick(); tick();
    chk("abort_pre_idle", 32'(state_ab), 32'h3);
    req0 = 1; op0 = 1; addr0 = 2'd1; wdata0 = 4'h9;
    tick(); req0 = 0; tick();
    chk("abort_pre_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", 32'(state_ab), 32'h3);
    chk("abort_we", 32'(mem_we), 32'h0);
    chk("abort_sel", 32'(mem_sel), 32'h0);
    chk("abort_ack", 32'({ack0, ack1}), 32'h0);
    chk("abort_rdata", 32'(rdata), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_ack", 32'({ack0, ack1}), 32'h0);
    end
    req0 = 1; req1 = 1; op0 = 0; op1 = 0;
    tick(); req0 = 0; req1 = 0; tick(); tick();
    chk("abort_rr_ack0", 32'(ack0), 32'h1);
    chk("abort_rr_ack1", 32'(ack1), 32'h0);
    tick();

    // ---- DEPTH=3: out-of-range addresses ----
    req0_3 = 1; op0_3 = 1; addr0_3 = 2'd3; wdata0_3 = 4'hF;
    tick(); req0_3 = 0;
    chk("d3_w_setup_sel", 32'(mem_sel_3), 32'h0);
    chk("d3_w_setup_we", 32'(mem_we_3), 32'h0);
    tick();
    chk("d3_w_access_sel", 32'(mem_sel_3), 32'h0);
    chk("d3_w_access_we", 32'(mem_we_3), 32'h0);
    tick();
    chk("d3_w_ack", 32'({ack1_3, ack0_3}), 32'h1);
    chk("d3_w_err", 32'(err_3), 32'h1);
    chk("d3_w_rdata", 32'(rdata_3), 32'h0);
    tick();
    chk("d3_err_hold", 32'(err_3), 32'h1);
    chk("d3_idle_ack", 32'(ack0_3), 32'h0);
    req0_3 = 1; op0_3 = 0; addr0_3 = 2'd3;
    tick(); req0_3 = 0; tick();
    chk("d3_r_access_sel", 32'(mem_sel_3), 32'h0);
    tick();
    chk("d3_r_ack", 32'(ack0_3), 32'h1);
    chk("d3_r_err", 32'(err_3), 32'h1);
    chk("d3_r_rdata", 32'(rdata_3), 32'h0);
    tick();
    req0_3 = 1; op0_3 = 0; addr0_3 = 2'd2;
    tick(); req0_3 = 0;
    chk("d3_ok_sel", 32'(mem_sel_3), 32'h4);
    tick(); tick();
    chk("d3_ok_ack", 32'(ack0_3), 32'h1);
    chk("d3_ok_err", 32'(err_3), 32'h0);
    chk("d3_ok_rdata", 32'(rdata_3), 32'hF);
    tick();

    run_inv = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
